// File: rtl/spst_mac_if.sv
`default_nettype none
// ============================================================================
// Module      : spst_mac_if
// Description : Operand/result bundle between the operand-issuing controller
//               (master) and the SPST multiplier core (slave).
//               start  - operation request
//               A, B   - 16-bit unsigned multiplicand / multiplier
//               done   - one-cycle completion pulse
//               result - 32-bit product, held until the next completion
// Revision    : 1.0 - initial release
// ============================================================================
interface spst_mac_if;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        done;
    logic [31:0] result;

    modport master (
        output start,
        output A,
        output B,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        output done,
        output result
    );
endinterface
`default_nettype wire

// File: rtl/spst_mac.sv
`default_nettype none
// ============================================================================
// Module      : spst_mac
// Description : Unsigned 16x16 multiplier using the Spurious Power Suppression
//               Technique. One multiplier nibble is processed per cycle over
//               four cycles; all-zero nibbles leave the adder operand and the
//               accumulator untouched. The 32-bit product is registered with
//               a one-cycle done pulse.
//   clk    - clock, rising edge
//   rst_n  - synchronous reset, active-high despite its name
//   bus    - slave side of spst_mac_if (start, A, B in; done, result out)
// Revision    : 1.0 - initial release
// ============================================================================
module spst_mac (
    input  wire logic  clk,
    input  wire logic  rst_n,
    spst_mac_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [31:0] r_acc;
    logic [31:0] r_op;      // adder operand latch, only refreshed on non-zero nibbles
    logic [1:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_done;

    logic        w_accept;
    logic        w_calc;
    logic        w_last;
    logic [3:0]  w_shamt;
    logic [3:0]  w_nib;
    logic        w_nz;
    logic [19:0] w_pp;
    logic [31:0] w_pp_sh;
    logic [31:0] w_add_op;
    logic [31:0] w_sum;
    logic [31:0] w_acc_nxt;

    // ------------------------------------------------------------------
    // Nibble datapath
    // ------------------------------------------------------------------
    assign w_shamt = {r_cnt, 2'b00};
    assign w_nib   = r_b[w_shamt +: 4];
    assign w_nz    = |w_nib;
    assign w_pp    = {4'b0000, r_a} * {16'h0000, w_nib};
    assign w_pp_sh = {12'h000, w_pp} << w_shamt;

    // For a zero nibble the adder keeps seeing its previous operand, so its
    // inputs do not toggle; the sum is discarded because acc is not enabled.
    assign w_add_op  = w_nz ? w_pp_sh : r_op;
    assign w_sum     = r_acc + w_add_op;
    assign w_acc_nxt = w_nz ? w_sum : r_acc;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // The edge that leaves DONE is the edge on which IDLE is re-entered;
    // a start present there is accepted directly, giving one operation
    // every five cycles. Starts seen during CALC are simply not recorded.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == 2'd3) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = bus.start ? S_CALC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_accept = 1'b0;
        w_calc   = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            S_IDLE:  w_accept = bus.start;
            S_CALC:  begin
                w_calc = 1'b1;
                w_last = (r_cnt == 2'd3);
            end
            S_DONE:  w_accept = bus.start;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_a      <= 16'h0000;
            r_b      <= 16'h0000;
            r_acc    <= 32'h0000_0000;
            r_op     <= 32'h0000_0000;
            r_cnt    <= 2'd0;
            r_result <= 32'h0000_0000;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a   <= bus.A;
                r_b   <= bus.B;
                r_acc <= 32'h0000_0000;
                r_cnt <= 2'd0;
            end else if (w_calc) begin
                r_cnt <= r_cnt + 2'd1;
                if (w_nz) begin
                    r_acc <= w_sum;
                    r_op  <= w_pp_sh;
                end
                // Final nibble: load the updated sum straight into result
                if (w_last) begin
                    r_result <= w_acc_nxt;
                end
            end
        end
    end

    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_spst_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_spst_mac
// Description : Self-checking bench for spst_mac. Expected products are
//               pushed to a scoreboard queue when an operation is issued and
//               popped when done is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spst_mac;

    logic clk = 1'b0;
    logic rst_n;

    spst_mac_if bus ();

    spst_mac dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // wait up to budget edges for done; lat = edge count, 0 on timeout
    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed done expected no done (empty scoreboard)", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, bus.result, e);
        end
    endtask

    // issue one operation with a 1-cycle start pulse and check it fully
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b);
        int lat;
        logic [31:0] held;
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        exp_q.push_back({16'h0000, a} * {16'h0000, b});
        step();                                   // accepting edge E0
        bus.start = 1'b0;
        bus.A     = 16'($urandom);                // operands may change freely now
        bus.B     = 16'($urandom);
        wait_done(8, lat);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        if (lat != 0) begin
            pop_check(tag);
            held = bus.result;
            step();
            check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
            check({tag, "_hold"}, bus.result, held);
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        int lat;
        int n_done;
        int first_at;
        int second_at;

        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.A     = 16'h0000;
        bus.B     = 16'h0000;
        step();
        step();
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        rst_n = 1'b0;

        // basic products with a gap
        run_op("mul_12x5", 16'd12, 16'd5);
        step(); step(); step();
        run_op("mul_18x4", 16'd18, 16'd4);
        run_op("mul_123x45", 16'd123, 16'd45);
        step();
        check("hold_5535", bus.result, 32'd5535);

        // corners
        run_op("max_x_max", 16'hFFFF, 16'hFFFF);
        run_op("b_zero", 16'h1234, 16'h0000);
        run_op("zero_nibbles", 16'h00FF, 16'h0F00);

        // second start during CALC is ignored
        bus.start = 1'b1;
        bus.A     = 16'd7;
        bus.B     = 16'd3;
        exp_q.push_back(32'd21);
        step();                                   // E0
        bus.start = 1'b0;
        step();                                   // E1
        bus.start = 1'b1;
        bus.A     = 16'd9;
        bus.B     = 16'd9;
        step();                                   // E2, in CALC
        bus.start = 1'b0;
        wait_done(8, lat);
        check("calc_start_latency", 32'(lat), 32'd2);
        if (lat != 0) pop_check("calc_start_result");
        else void'(exp_q.pop_front());
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.done === 1'b1) n_done++;
        end
        check("calc_start_no_second", 32'(n_done), 32'd0);
        check("calc_start_hold", bus.result, 32'd21);

        // reset in the middle of CALC aborts without a done
        bus.start = 1'b1;
        bus.A     = 16'd100;
        bus.B     = 16'd100;
        step();                                   // E0
        bus.start = 1'b0;
        step();                                   // E1
        rst_n = 1'b1;
        step();
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_result", bus.result, 32'd0);
        rst_n  = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.done === 1'b1) n_done++;
        end
        check("midrst_no_done", 32'(n_done), 32'd0);
        run_op("after_rst_2x3", 16'd2, 16'd3);

        // start held high for 10 cycles: operations back to back every 5 cycles
        exp_q.push_back(32'd25);
        exp_q.push_back(32'd25);
        bus.A     = 16'd5;
        bus.B     = 16'd5;
        n_done    = 0;
        first_at  = -1;
        second_at = -1;
        for (int i = 0; i < 16; i++) begin
            bus.start = (i < 10);
            step();                               // edge Ei
            if (bus.done === 1'b1) begin
                n_done++;
                if (first_at < 0) first_at = i;
                else if (second_at < 0) second_at = i;
                pop_check("held_start_result");
            end
        end
        bus.start = 1'b0;
        check("held_start_count", 32'(n_done), 32'd2);
        check("held_start_first", 32'(first_at), 32'd4);
        check("held_start_second", 32'(second_at), 32'd9);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global time limit so the bench always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
